// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus controller: FSM encoding, IO register
// offsets and channel/counter widths.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAM_WAIT = 2'd1,
        ST_TX_WAIT  = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_RX_STAT = 2'd1;
    localparam logic [1:0] REG_TX_STAT = 2'd2;

    localparam int IO_STRIDE = 4;
    localparam int CH_W      = 4;
    localparam int WAIT_W    = 4;

endpackage

// File: rtl/mem_bus_decode.sv
// Combinational address decode: IO window hit, UART channel index and register offset.
module mem_bus_decode
    import mem_bus_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter int unsigned IO_BASE  = 32'h0400,
    parameter int          NUM_UART = 2
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_is_io,
    output logic [CH_W-1:0]   o_ch,
    output logic [1:0]        o_reg
);

    // One extra bit so the window end cannot wrap at the top of the address space.
    localparam logic [ADDR_W:0] LP_LO = (ADDR_W+1)'(IO_BASE);
    localparam logic [ADDR_W:0] LP_HI = (ADDR_W+1)'(IO_BASE + IO_STRIDE * NUM_UART);

    logic [ADDR_W:0] w_addr;
    logic [ADDR_W:0] w_off;
    logic [ADDR_W:0] w_off_sh;

    assign w_addr   = {1'b0, i_addr};
    assign w_off    = w_addr - LP_LO;
    assign w_off_sh = w_off >> 2;
    assign o_is_io  = (w_addr >= LP_LO) && (w_addr < LP_HI);
    assign o_ch     = CH_W'(w_off_sh);
    assign o_reg    = i_addr[1:0];

endmodule

// File: rtl/mem_bus_ctrl.sv
// Core memory bus controller: routes each latched core access either to RAM
// (fixed wait latency) or to a UART channel register, then pulses MEM_data_ready.
//
//   state       | meaning
//   ST_IDLE     | ready for MEM_exec; with a latched request, decode and dispatch
//   ST_RAM_WAIT | RAM strobe issued, counting down RAM_LATENCY before capture
//   ST_TX_WAIT  | UART tx write pending until the transmitter reports ready
//   ST_DONE     | completion pulse; a new request may be accepted here
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int          ADDR_W      = 16,
    parameter int          DATA_W      = 16,
    parameter int          NUM_UART    = 2,
    parameter int unsigned IO_BASE     = 32'h0400,
    parameter int          RAM_LATENCY = 2
) (
    input  logic                  I_clk,
    input  logic                  I_reset_n,
    input  logic                  MEM_exec,
    input  logic                  MEM_write,
    input  logic [1:0]            MEM_size,
    input  logic [ADDR_W-1:0]     MEM_addr,
    input  logic [DATA_W-1:0]     MEM_data_out,
    output logic [DATA_W-1:0]     MEM_data_in,
    output logic                  MEM_ready,
    output logic                  MEM_data_ready,
    output logic                  O_ram_enable,
    output logic                  O_ram_write,
    output logic [1:0]            O_ram_size,
    output logic [ADDR_W-1:0]     O_ram_addr,
    output logic [DATA_W-1:0]     O_ram_data,
    input  logic [DATA_W-1:0]     I_ram_data,
    output logic [NUM_UART-1:0]   O_tx_exec,
    output logic [8*NUM_UART-1:0] O_tx_data,
    input  logic [NUM_UART-1:0]   I_tx_ready,
    input  logic [8*NUM_UART-1:0] I_rx_data,
    input  logic [NUM_UART-1:0]   I_rx_data_ready,
    output logic [NUM_UART-1:0]   O_rx_ack
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_pend;
    logic                  r_write;
    logic [1:0]            r_size;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [NUM_UART-1:0]   r_rx_rdy_lat;
    logic [WAIT_W-1:0]     r_wait;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_ram_en;
    logic [NUM_UART-1:0]   r_tx_exec;
    logic [8*NUM_UART-1:0] r_tx_data;
    logic [NUM_UART-1:0]   r_rx_ack;

    logic                  w_is_io;
    logic [CH_W-1:0]       w_ch;
    logic [1:0]            w_reg;
    logic [NUM_UART-1:0]   w_ch_oh;
    logic                  w_tx_rdy_sel;
    logic                  w_rx_rdy_sel;
    logic                  w_rx_lat_sel;
    logic [7:0]            w_rx_byte;

    logic                  w_accept;
    logic                  w_mem_ready;
    logic                  w_ram_en_nxt;
    logic [WAIT_W-1:0]     w_wait_nxt;
    logic                  w_rdata_ld;
    logic [DATA_W-1:0]     w_rdata_val;
    logic [NUM_UART-1:0]   w_tx_exec_nxt;
    logic [8*NUM_UART-1:0] w_tx_data_nxt;
    logic [NUM_UART-1:0]   w_rx_ack_nxt;

    mem_bus_decode #(
        .ADDR_W   (ADDR_W),
        .IO_BASE  (IO_BASE),
        .NUM_UART (NUM_UART)
    ) u_decode (
        .i_addr  (r_addr),
        .o_is_io (w_is_io),
        .o_ch    (w_ch),
        .o_reg   (w_reg)
    );

    always_comb begin
        w_ch_oh      = '0;
        w_tx_rdy_sel = 1'b0;
        w_rx_rdy_sel = 1'b0;
        w_rx_lat_sel = 1'b0;
        w_rx_byte    = 8'h00;
        for (int k = 0; k < NUM_UART; k++) begin
            if (w_ch == CH_W'(k)) begin
                w_ch_oh[k]   = 1'b1;
                w_tx_rdy_sel = I_tx_ready[k];
                w_rx_rdy_sel = I_rx_data_ready[k];
                w_rx_lat_sel = r_rx_rdy_lat[k];
                w_rx_byte    = I_rx_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_mem_ready   = 1'b0;
        w_ram_en_nxt  = 1'b0;
        w_wait_nxt    = r_wait;
        w_rdata_ld    = 1'b0;
        w_rdata_val   = r_rdata;
        w_tx_exec_nxt = '0;
        w_rx_ack_nxt  = '0;
        w_tx_data_nxt = '0;

        case (r_state)
            ST_IDLE: begin
                if (!r_pend) begin
                    w_mem_ready = 1'b1;
                    w_accept    = MEM_exec;
                end else if (!w_is_io) begin
                    w_state_nxt  = ST_RAM_WAIT;
                    w_ram_en_nxt = 1'b1;
                    w_wait_nxt   = WAIT_W'(RAM_LATENCY);
                end else if (r_write && (w_reg == REG_DATA)) begin
                    w_state_nxt = ST_TX_WAIT;
                end else begin
                    w_state_nxt = ST_DONE;
                    if (!r_write) begin
                        w_rdata_ld = 1'b1;
                        case (w_reg)
                            REG_DATA: begin
                                w_rdata_val  = DATA_W'(w_rx_byte);
                                // Pop only a byte that was valid when the request was latched.
                                w_rx_ack_nxt = w_ch_oh & {NUM_UART{w_rx_lat_sel}};
                            end
                            REG_RX_STAT: w_rdata_val = {{(DATA_W-1){1'b0}}, w_rx_rdy_sel};
                            REG_TX_STAT: w_rdata_val = {{(DATA_W-1){1'b0}}, w_tx_rdy_sel};
                            default:     w_rdata_val = '0;
                        endcase
                    end
                end
            end
            ST_RAM_WAIT: begin
                if (r_wait == '0) begin
                    w_state_nxt = ST_DONE;
                    w_rdata_ld  = !r_write;
                    w_rdata_val = I_ram_data;
                end else begin
                    w_wait_nxt = r_wait - 1'b1;
                end
            end
            ST_TX_WAIT: begin
                if (w_tx_rdy_sel) begin
                    w_state_nxt   = ST_DONE;
                    w_tx_exec_nxt = w_ch_oh;
                end
            end
            ST_DONE: begin
                w_mem_ready = 1'b1;
                w_accept    = MEM_exec;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        for (int k = 0; k < NUM_UART; k++) begin
            w_tx_data_nxt[8*k +: 8] = w_tx_exec_nxt[k] ? r_wdata[7:0] : 8'h00;
        end
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_pend       <= 1'b0;
            r_write      <= 1'b0;
            r_size       <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rx_rdy_lat <= '0;
            r_wait       <= '0;
            r_rdata      <= '0;
            r_ram_en     <= 1'b0;
            r_tx_exec    <= '0;
            r_tx_data    <= '0;
            r_rx_ack     <= '0;
        end else begin
            r_pend    <= w_accept;
            r_wait    <= w_wait_nxt;
            r_ram_en  <= w_ram_en_nxt;
            r_tx_exec <= w_tx_exec_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_rx_ack  <= w_rx_ack_nxt;
            if (w_accept) begin
                r_write      <= MEM_write;
                r_size       <= MEM_size;
                r_addr       <= MEM_addr;
                r_wdata      <= MEM_data_out;
                r_rx_rdy_lat <= I_rx_data_ready;
            end
            if (w_rdata_ld) begin
                r_rdata <= w_rdata_val;
            end
        end
    end

    assign MEM_ready      = w_mem_ready;
    assign MEM_data_ready = (r_state == ST_DONE);
    assign MEM_data_in    = r_rdata;
    assign O_ram_enable   = r_ram_en;
    assign O_ram_write    = r_ram_en & r_write;
    assign O_ram_size     = r_size;
    assign O_ram_addr     = r_addr;
    assign O_ram_data     = r_wdata;
    assign O_tx_exec      = r_tx_exec;
    assign O_tx_data      = r_tx_data;
    assign O_rx_ack       = r_rx_ack;

endmodule
